// File: rtl/tx_seq_ctrl.sv
// tx_seq_ctrl: steps a 40-bit mux index at CLK_DIV clocks per bit with optional idle gaps between 10-bit characters
module tx_seq_ctrl #(
  parameter logic [15:0] CLK_DIV = 16'd5208,
  parameter logic [3:0]  GAP_BITS = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       repeat_en,
  input  logic       mpx_txd,
  output logic [5:0] sel,
  output logic       txd_out,
  output logic       busy,
  output logic       done,
  output logic       bit_tick
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_nx;
  logic [5:0] sel_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0] gcnt, gcnt_nx;
  logic txd_nx, done_nx, bit_end, char_end, last_bit, gap_end;
  assign bit_end = cnt == CLK_DIV - 16'd1;
  assign char_end = sel == 6'd9 || sel == 6'd19 || sel == 6'd29;
  assign last_bit = sel == 6'd39;
  assign gap_end = bit_end && gcnt == GAP_BITS - 4'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      gcnt <= '0;
      txd_out <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      cnt <= cnt_nx;
      gcnt <= gcnt_nx;
      txd_out <= txd_nx;
      done <= done_nx;
    end
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    cnt_nx = bit_end ? 16'd0 : cnt + 16'd1;
    gcnt_nx = gcnt;
    done_nx = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      sel_nx = '0;
      cnt_nx = '0;
      gcnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          gcnt_nx = '0;
          sel_nx = '0;
          state_nx = start ? SEND : IDLE;
        end
        SEND: if (bit_end) begin
          if (last_bit && !repeat_en) begin
            state_nx = IDLE;
            sel_nx = '0;
            done_nx = 1'b1;
          end else if ((last_bit || char_end) && GAP_BITS != 4'd0) begin
            state_nx = GAP;
            gcnt_nx = '0;
          end else
            sel_nx = last_bit ? 6'd0 : sel + 6'd1;
        end
        GAP: if (bit_end) begin
          gcnt_nx = gcnt + 4'd1;
          if (gap_end) begin
            state_nx = SEND;
            sel_nx = last_bit ? 6'd0 : sel + 6'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_comb begin
    busy = state != IDLE;
    bit_tick = busy && bit_end;
    txd_nx = abort ? 1'b1 : (state == SEND ? mpx_txd : 1'b1);
  end
endmodule

// File: tb/tb_tx_seq_ctrl.sv
// tb_tx_seq_ctrl: randomized checks of two tx_seq_ctrl instances (no gap, 2-bit gap) against a per-cycle timeline model
module tb_tx_seq_ctrl;
  logic clk = 0, rst = 0;
  logic start_a = 0, start_b = 0, abort_a = 0, abort_b = 0, rep_a = 0, rep_b = 0;
  logic [5:0] sel_a, sel_b, o_sel;
  logic txd_a, txd_b, busy_a, busy_b, done_a, done_b, tick_a, tick_b;
  logic o_txd, o_busy, o_done, o_tick, mpx_a, mpx_b, exp_txd;
  logic g2 = 0;
  logic [39:0] pat = 40'h0;
  int n_checks = 0, n_fail = 0;
  int q_sel[$];
  bit q_send[$];

  always #5 clk = ~clk;

  assign mpx_a = pat[sel_a];
  assign mpx_b = pat[sel_b];
  assign o_sel = g2 ? sel_b : sel_a;
  assign o_txd = g2 ? txd_b : txd_a;
  assign o_busy = g2 ? busy_b : busy_a;
  assign o_done = g2 ? done_b : done_a;
  assign o_tick = g2 ? tick_b : tick_a;

  tx_seq_ctrl #(.CLK_DIV(16'd4), .GAP_BITS(4'd0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .repeat_en(rep_a), .mpx_txd(mpx_a),
    .sel(sel_a), .txd_out(txd_a), .busy(busy_a), .done(done_a), .bit_tick(tick_a));

  tx_seq_ctrl #(.CLK_DIV(16'd4), .GAP_BITS(4'd2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .repeat_en(rep_b), .mpx_txd(mpx_b),
    .sel(sel_b), .txd_out(txd_b), .busy(busy_b), .done(done_b), .bit_tick(tick_b));

  task automatic drive_start(input logic v);
    if (g2) start_b = v; else start_a = v;
  endtask

  task automatic drive_abort(input logic v);
    if (g2) abort_b = v; else abort_a = v;
  endtask

  task automatic drive_rep(input logic v);
    if (g2) rep_b = v; else rep_a = v;
  endtask

  // One entry per clock from the first busy cycle: bit index and whether the line carries data.
  function automatic void build(input bit rep);
    int gc = g2 ? 8 : 0;
    q_sel.delete();
    q_send.delete();
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < 4; c++) begin q_sel.push_back(k); q_send.push_back(1); end
      if (k == 9 || k == 19 || k == 29 || (k == 39 && rep))
        for (int c = 0; c < gc; c++) begin q_sel.push_back(k); q_send.push_back(0); end
    end
  endfunction

  task automatic new_pattern();
    pat[39:32] = 8'($urandom);
    pat[31:10] = 22'($urandom);
    pat[9:0] = 10'b10_1100_0010;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({sel_a, sel_b} !== 12'd0 || {txd_a, txd_b} !== 2'b11 || {busy_a, busy_b, done_a, done_b, tick_a, tick_b} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_async: sel=%0d/%0d txd=%b/%b busy=%b/%b done=%b/%b tick=%b/%b, want 0/0 1/1 0 0 0",
               sel_a, sel_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b, tick_a, tick_b);
    end
    start_a = 1;
    start_b = 1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, busy_b, sel_a, sel_b} !== 14'd0 || {txd_a, txd_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b/%b sel=%0d/%0d txd=%b/%b, want idle", busy_a, busy_b, sel_a, sel_b, txd_a, txd_b);
    end
    start_a = 0;
    start_b = 0;
  endtask

  task automatic test_sequence(input bit which, input bit rep);
    int n;
    g2 = which;
    build(rep);
    new_pattern();
    drive_rep(rep);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    n = q_sel.size();
    for (int i = 0; i < n; i++) begin
      exp_txd = (i == 0) ? 1'b1 : (q_send[i-1] ? pat[q_sel[i-1]] : 1'b1);
      n_checks++;
      if (o_sel !== 6'(q_sel[i]) || o_busy !== 1'b1 || o_done !== 1'b0 || o_tick !== (i % 4 == 3) || o_txd !== exp_txd) begin
        n_fail++;
        $display("FAIL seq_g%0d_r%0d t=%0d: sel=%0d busy=%b done=%b tick=%b txd=%b, want sel=%0d busy=1 done=0 tick=%b txd=%b",
                 which, rep, i, o_sel, o_busy, o_done, o_tick, o_txd, q_sel[i], (i % 4 == 3), exp_txd);
      end
      @(negedge clk);
    end
    exp_txd = q_send[n-1] ? pat[q_sel[n-1]] : 1'b1;
    n_checks++;
    if (o_done !== !rep || o_busy !== rep || o_sel !== 6'd0 || o_txd !== exp_txd) begin
      n_fail++;
      $display("FAIL seq_end_g%0d_r%0d t=%0d: done=%b busy=%b sel=%0d txd=%b, want done=%b busy=%b sel=0 txd=%b",
               which, rep, n, o_done, o_busy, o_sel, o_txd, !rep, rep, exp_txd);
    end
    if (rep) drive_abort(1);
    @(negedge clk);
    drive_abort(0);
    drive_rep(0);
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_txd !== 1'b1 || o_sel !== 6'd0) begin
      n_fail++;
      $display("FAIL seq_after_g%0d_r%0d: done=%b busy=%b txd=%b sel=%0d, want 0 0 1 0", which, rep, o_done, o_busy, o_txd, o_sel);
    end
  endtask

  task automatic test_abort(input bit which);
    int bad = 0, t = 0;
    g2 = which;
    new_pattern();
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    while (o_sel !== 6'd17 && t < 400) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 400) begin n_fail++; $display("FAIL abort_reach17: sel=%0d after %0d cycles, want 17", o_sel, t); end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    drive_abort(1);
    drive_start(1);
    @(negedge clk);
    drive_abort(0);
    drive_start(0);
    n_checks++;
    if (o_busy !== 1'b0 || o_sel !== 6'd0 || o_txd !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_g%0d: busy=%b sel=%0d txd=%b done=%b, want 0 0 1 0", which, o_busy, o_sel, o_txd, o_done);
    end
    repeat (200) begin @(negedge clk); if (o_busy !== 1'b0 || o_done !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL abort_quiet_g%0d: %0d busy/done cycles, want 0", which, bad); end
  endtask

  task automatic test_async_reset(input bit which);
    int t = 0, bad = 0;
    g2 = which;
    new_pattern();
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    while (o_sel !== 6'd25 && t < 400) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 400) begin n_fail++; $display("FAIL rst_reach25: sel=%0d after %0d cycles, want 25", o_sel, t); end
    #2 rst = 1;
    #1;
    n_checks++;
    if (o_sel !== 6'd0 || o_txd !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_g%0d: sel=%0d txd=%b busy=%b done=%b tick=%b, want 0 1 0 0 0", which, o_sel, o_txd, o_busy, o_done, o_tick);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) begin @(negedge clk); if (o_busy !== 1'b0 || o_done !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_release_g%0d: %0d active cycles without start, want 0", which, bad); end
  endtask

  task automatic test_back_to_back();
    int dones = 0, es;
    bit eb;
    g2 = 0;
    new_pattern();
    drive_rep(0);
    drive_start(1);
    @(negedge clk);
    for (int t = 0; t <= 321; t++) begin
      eb = !(t == 160 || t == 321);
      es = (t < 160) ? t / 4 : ((t > 160 && t < 321) ? (t - 161) / 4 : 0);
      if (o_done === 1'b1) dones++;
      n_checks++;
      if (o_busy !== eb || o_done !== !eb || o_sel !== 6'(es)) begin
        n_fail++;
        $display("FAIL b2b t=%0d: busy=%b done=%b sel=%0d, want busy=%b done=%b sel=%0d", t, o_busy, o_done, o_sel, eb, !eb, es);
      end
      if (t == 321) drive_start(0);
      @(negedge clk);
    end
    n_checks++;
    if (dones != 2 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d busy=%b, want 2 and 0", dones, o_busy);
    end
  endtask

  initial begin
    #1 rst = 1;
    #1 test_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_sequence(0, 0);
    test_sequence(1, 0);
    test_sequence(1, 1);
    test_sequence(0, 1);
    test_abort(0);
    test_abort(1);
    test_async_reset(1);
    test_sequence(1, 0);
    test_async_reset(0);
    test_sequence(0, 0);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
